// File: rtl/ring_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_cnt_pkg
//  Description : Shared types and helpers for the ring/johnson counter.
//                It defines the sequence-mode enum and the seed function.
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_cnt_pkg;

    // Sequence type selected by the mode input.
    typedef enum logic {
        RC_RING    = 1'b0,
        RC_JOHNSON = 1'b1
    } rc_mode_e;

    // Widest counter the helper is sized for.
    localparam int C_MAX_WIDTH = 32;

    // Starting state of each sequence.
    // Ring mode starts with bit0 set.
    // Johnson mode starts at all-zero.
    // The result is masked to the counter width.
    function automatic logic [C_MAX_WIDTH-1:0] rc_seed(input int unsigned width,
                                                       input rc_mode_e    m);
        logic [C_MAX_WIDTH-1:0] mask;
        mask = (width >= C_MAX_WIDTH) ? {C_MAX_WIDTH{1'b1}}
                                      : ((32'd1 << width) - 32'd1);
        return (m == RC_RING) ? (32'd1 & mask) : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_state_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ring_state_decode
//  Description : Combinational decode of the counter state.
//                It reports whether the state is legal for the mode and
//                gives the state's position within the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_state_decode
    import ring_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] cnt,
    input  rc_mode_e         mode,
    output logic             legal,
    output logic [IDXW-1:0]  idx
);

    logic [WIDTH-1:0] cnt_inv;
    logic             thermo_lo;
    logic             thermo_hi;
    int               pop;
    int               pos;

    assign cnt_inv = ~cnt;

    // A run of ones anchored at bit0 turns into a single carry when 1 is added.
    // Such a state therefore has no ones in common with cnt + 1.
    assign thermo_lo = ((cnt & (cnt + WIDTH'(1))) == '0);

    // A run of ones anchored at the MSB is the same test applied to the inverted value.
    assign thermo_hi = ((cnt_inv & (cnt_inv + WIDTH'(1))) == '0);

    // Count the set bits and remember the highest set position.
    always_comb begin
        pop = 0;
        pos = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt[i]) begin
                pop = pop + 1;
                pos = i;
            end
        end
    end

    // Legality and sequence position, chosen by the sequence type.
    always_comb begin
        legal = 1'b0;
        idx   = '0;
        if (mode == RC_RING) begin
            legal = (pop == 1);
            idx   = (pop == 1) ? IDXW'(pos) : '0;
        end else begin
            legal = thermo_lo | thermo_hi;
            if (cnt == '0)
                idx = '0;
            else if (cnt[0])
                idx = IDXW'(pop);
            else
                idx = IDXW'(2*WIDTH - pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_johnson_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_johnson_counter
//  Description : Up/down counter with two selectable sequences.
//                The ring sequence is one-hot; the johnson sequence is a
//                twisted ring. The counter supports synchronous load and
//                recovers from illegal states.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_johnson_counter
    import ring_cnt_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       mode,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_val,
    output logic [WIDTH-1:0]           cnt,
    output logic [$clog2(2*WIDTH)-1:0] idx,
    output logic                       wrap,
    output logic                       err
);

    localparam int IDXW = $clog2(2*WIDTH);

    rc_mode_e         mode_in;
    rc_mode_e         mode_q;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] step_val;
    logic             legal;

    assign mode_in = rc_mode_e'(mode);

    // Seed for the requested mode; used on reset and on a mode change.
    assign seed_in = WIDTH'(rc_seed(WIDTH, mode_in));

    // Seed for the mode in effect; used for recovery and wrap detection.
    assign seed_q  = WIDTH'(rc_seed(WIDTH, mode_q));

    // Legality and position are judged against the mode the state was built in.
    ring_state_decode #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_decode (
        .cnt   (cnt),
        .mode  (mode_q),
        .legal (legal),
        .idx   (idx)
    );

    // Compute the one-step successor in the current direction and sequence.
    always_comb begin
        step_val = cnt;
        if (mode_q == RC_RING)
            step_val = dir ? {cnt[0], cnt[WIDTH-1:1]}
                           : {cnt[WIDTH-2:0], cnt[WIDTH-1]};
        else
            step_val = dir ? {~cnt[0], cnt[WIDTH-1:1]}
                           : {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
    end

    // Update the state register with priority: load, mode change, recovery, step.
    // The mode register and the status pulses are updated here as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= seed_in;
            mode_q <= mode_in;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mode_q <= mode_in;
            wrap   <= 1'b0;
            err    <= 1'b0;
            if (load) begin
                cnt <= load_val;
            end else if (mode_in != mode_q) begin
                cnt <= seed_in;
            end else if (!legal) begin
                cnt <= seed_q;
                err <= 1'b1;
            end else if (en) begin
                cnt  <= step_val;
                wrap <= (step_val == seed_q);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ring_johnson_counter.md
RING_JOHNSON_COUNTER -- requirements
Module: ring_johnson_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter register width, legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port en  input  1  advance one step when high.
REQ-005 SHALL have port dir  input  1  step direction: 0 = up (shift toward MSB), 1 = down (shift toward LSB).
REQ-006 SHALL have port mode  input  1  sequence type: 0 = ring (one-hot), 1 = johnson (twisted ring).
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  WIDTH  value written on load.
REQ-009 SHALL have port cnt  output  WIDTH  registered counter state.
REQ-010 SHALL have port idx  output  $clog2(2*WIDTH)  sequence position of cnt, combinational from cnt.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse, step landed on seed.
REQ-012 SHALL have port err  output  1  registered one-cycle pulse, illegal state recovered.

Function
REQ-013 Seed SHALL be 1 (bit0 set) in ring mode and all-zero in johnson mode.
REQ-014 Ring up step SHALL rotate left (MSB to bit0); ring down SHALL rotate right (bit0 to MSB); period WIDTH.
REQ-015 Johnson up step SHALL shift left with new bit0 = ~old MSB; johnson down SHALL shift right with new MSB = ~old bit0; period 2*WIDTH.
REQ-016 Ring legal states SHALL be exactly-one-hot; johnson legal states SHALL be contiguous ones anchored at bit0, or contiguous ones anchored at MSB, or all-zero.
REQ-017 Next-state priority SHALL be: load > mode change > illegal recovery > step > hold.
REQ-018 load=1 SHALL write load_val into cnt next edge unmodified, no wrap, no err.
REQ-019 A mode change (mode differs from registered mode_q) without load SHALL set cnt to the new mode's seed next edge, no wrap, no err.
REQ-020 If cnt is illegal for mode_q and no load/mode change, cnt SHALL become seed next edge regardless of en, and err SHALL pulse high one cycle.
REQ-021 With en=0 and no higher-priority event, cnt SHALL hold.
REQ-022 wrap SHALL be high in the cycle after a step edge whose result equals seed; never for load, mode change or recovery.
REQ-023 idx in ring mode SHALL be the bit position of the set bit; illegal cnt SHALL give idx 0.
REQ-024 idx in johnson mode SHALL be 0 for all-zero, popcount(cnt) when bit0=1, else 2*WIDTH - popcount(cnt).
REQ-025 Step latency SHALL be one clock: cnt changes on the edge where en is sampled.

Reset
REQ-026 rst_n=0 at an edge SHALL set cnt to seed of the current mode input, mode_q=mode, wrap=0, err=0.
REQ-027 Reset SHALL override load, en and recovery; reset mid-sequence SHALL discard state without err.
REQ-028 No initial blocks; all state SHALL be reset-defined.

Structure
REQ-029 Package ring_cnt_pkg SHALL hold the mode enum (RC_RING, RC_JOHNSON) and a seed function of WIDTH and mode.
REQ-030 Legality check and idx decode SHALL live in sub-module ring_state_decode (inputs cnt, mode; outputs legal, idx), purely combinational.
REQ-031 Top level SHALL contain only the state register, next-state mux, mode_q, wrap and err registers.

Verification (WIDTH=4)
REQ-032 Reset, mode=0, en=1, dir=0, 5 clocks -> cnt 0001,0010,0100,1000,0001; wrap high once after the 1000->0001 edge; idx 0,1,2,3,0.
REQ-033 mode=1, en=1, dir=0 from reset, 8 clocks -> 0001,0011,0111,1111,1110,1100,1000,0000; idx 1..7,0; wrap after 1000->0000.
REQ-034 Johnson at 0111, dir=1 for 3 clocks -> 0011,0001,0000; wrap after last edge.
REQ-035 Ring mode, load=1 load_val=0110 -> cnt 0110, no err; next edge -> cnt 0001, err pulse exactly one cycle, en ignored.
REQ-036 Ring at 0100, mode toggled to 1 with load=1 load_val=0011 -> cnt 0011, no err; next edge with load=0, en=1 -> 0111.
REQ-037 Johnson at 1110, rst_n=0 with en=1 and load=1 -> cnt 0000, wrap=0, err=0 next edge.
